data_table_search_pool: RTL and testbench
=========================================

# data_table_search_pool

Pool of ENGINES_CNT hash-chain search engines that share one data-table RAM read port. Search tasks (bucket head pointer plus key) are dispatched to free engines. RAM read slots are time-multiplexed round-robin among the engines, and completed results are merged onto one valid/ready result stream. The pool sits between the bucket/head-pointer stage and the hash-table result output. It adds task dispatch, an empty-bucket shortcut, a chain-length guard, result arbitration and ENGINES_CNT=1 support.

## Interface
- ENGINES_CNT, 4: number of engines; 1..16 legal.
- RAM_LATENCY, 2: cycles from rd_en_o to valid rd_data_i; >=1.
- A_WIDTH, TABLE_ADDR_WIDTH: RAM address width.
- MAX_CHAIN, 16: maximum reads per task before abort.
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- task_i  in  ht_search_task_t  fields key, head_ptr[A_WIDTH], head_ptr_val, id.
- task_valid_i  in  1  task offered.
- task_ready_o  out  1  at least one engine IDLE.
- rd_addr_o  out  A_WIDTH  RAM read address.
- rd_en_o  out  1  RAM read strobe.
- rd_data_i  in  ram_data_t  fields key, value, next_ptr, next_ptr_val.
- result_o  out  ht_search_res_t  fields id, key, value, status (FOUND, NOT_FOUND, CHAIN_LIMIT).
- result_valid_o  out  1  result offered.
- result_ready_i  in  1  result consumed.

## Operation
- Dispatch: a task is accepted when task_valid_i && task_ready_o. It goes to the lowest-index IDLE engine, which latches task_i.
- Engine FSM states:
  - IDLE: on accept, go to DONE with NOT_FOUND if head_ptr_val=0; otherwise go to WAIT_SLOT with addr=head_ptr and hops=0.
  - WAIT_SLOT: issue a read of addr in the first cycle where the slot pointer equals this engine's index, then go to WAIT_DATA.
  - WAIT_DATA: on the tagged data-valid, compare rd_data_i.key with the task key.
    - Key matches: DONE, FOUND, value latched.
    - Otherwise, if next_ptr_val=0: DONE, NOT_FOUND.
    - Otherwise, if hops+1=MAX_CHAIN: DONE, CHAIN_LIMIT.
    - Otherwise: addr=next_ptr, hops++, back to WAIT_SLOT.
  - DONE: hold the result and request output. Go to IDLE on output handshake.
- Slot pointer: binary counter 0..ENGINES_CNT-1 that wraps, advancing every cycle; constant 0 when ENGINES_CNT=1. At most one engine can read per cycle, so there are no RAM collisions.
- Read-return routing: a RAM_LATENCY-deep shift register carries {valid, engine index} of each issued read. Its output marks which engine owns rd_data_i.
- Result arbitration: round-robin over DONE engines, starting after the last granted index.
  - The grant is frozen while result_valid_o && !result_ready_i.
  - On handshake, the pointer moves past the granted engine.
- A result's value field is 0 unless status=FOUND. The id, key and status fields always copy the task.
- Results may leave out of task order; consumers reorder by id.

## Timing
- Reset values: rd_en_o=0, rd_addr_o=0, task_ready_o=0 during reset then 1, result_valid_o=0, result_o=0, slot pointer=0, all engines IDLE, tag line cleared.
- rd_en_o and rd_addr_o are driven only from registers (engine state, slot pointer); there is no combinational path from any input.
- Read issued in cycle R: data is consumed at R+RAM_LATENCY; the engine state updates at R+RAM_LATENCY+1.
- Empty-bucket task accepted at T: result_valid_o=1 at T+1.
- Single-hop hit with an idle slot: result_valid_o at T+1+(slot wait 0..ENGINES_CNT-1)+RAM_LATENCY+1.
- task_ready_o is combinational from engine states. An engine freed by a result handshake in cycle C can accept a task from C+1.
- Simultaneous accept and result handshake on different engines in the same cycle: both take effect.
- Reset mid-search: everything is aborted, and in-flight RAM returns are ignored because the tag line is cleared.

## Structure
- Package hash_table holds ht_search_task_t, ht_search_res_t, the status enum, ram_data_t and TABLE_ADDR_WIDTH.
- Sub-module data_table_search_engine holds one FSM plus its task/result registers and is instantiated ENGINES_CNT times.
- Slot counter, tag shift register, dispatch priority encoder and result arbiter stay in the top level.

## Test plan
- Empty bucket: task {id=3, head_ptr_val=0} -> one cycle later, result {id=3, NOT_FOUND, value=0}; rd_en_o never asserted.
- Hit at hop 3: chain 0x10->0x22->0x35, key matches at 0x35 -> reads exactly 0x10, 0x22, 0x35; FOUND with the stored value.
- Chain guard: MAX_CHAIN=4 with a cyclic chain 0x01->0x02->0x01... -> exactly 4 reads, then CHAIN_LIMIT.
- Saturation: 4 engines, 6 tasks back-to-back -> task_ready_o drops after the 4th accept.
  - rd_en_o is never issued by two engines in one slot.
  - Each engine reads only in its own slot index.
  - All 6 ids are returned once each.
- Backpressure: hold result_ready_i=0 for 20 cycles with 3 engines DONE -> result_o stays constant. Releasing it drains results in round-robin order 0, 1, 2.
- Reset mid-search with RAM_LATENCY=3: assert rst_i one cycle after a read -> all outputs return to reset values. The late RAM data causes no result.

Source files
------------

// File: rtl/data_table_search_pool_pkg.sv
// Shared hash-table types: search tasks, search results and data-table RAM words.
package hash_table;

    localparam int unsigned TABLE_ADDR_WIDTH = 8;
    localparam int unsigned KEY_WIDTH        = 16;
    localparam int unsigned VALUE_WIDTH      = 16;
    localparam int unsigned ID_WIDTH         = 4;

    typedef enum logic [1:0] {
        NOT_FOUND   = 2'd0,
        FOUND       = 2'd1,
        CHAIN_LIMIT = 2'd2
    } ht_status_t;

    typedef struct packed {
        logic [KEY_WIDTH-1:0]        key;
        logic [TABLE_ADDR_WIDTH-1:0] head_ptr;
        logic                        head_ptr_val;
        logic [ID_WIDTH-1:0]         id;
    } ht_search_task_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]    id;
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
        ht_status_t             status;
    } ht_search_res_t;

    typedef struct packed {
        logic [KEY_WIDTH-1:0]        key;
        logic [VALUE_WIDTH-1:0]      value;
        logic [TABLE_ADDR_WIDTH-1:0] next_ptr;
        logic                        next_ptr_val;
    } ram_data_t;

endpackage

// File: rtl/data_table_search_pool_if.sv
// Task-in / result-out streams of the search pool; the pool uses the slave side.
interface data_table_search_pool_if;
    import hash_table::*;

    ht_search_task_t task_i;
    logic            task_valid_i;
    logic            task_ready_o;
    ht_search_res_t  result_o;
    logic            result_valid_o;
    logic            result_ready_i;

    modport master (
        output task_i, task_valid_i, result_ready_i,
        input  task_ready_o, result_o, result_valid_o
    );

    modport slave (
        input  task_i, task_valid_i, result_ready_i,
        output task_ready_o, result_o, result_valid_o
    );
endinterface

// File: rtl/data_table_search_pool_engine.sv
// One hash-chain walker: holds a task, requests RAM reads in its slot, follows
// next pointers until hit, end of chain or hop limit, then offers the result.
module data_table_search_engine
    import hash_table::*;
#(
    parameter int unsigned MAX_CHAIN = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  ht_search_task_t             task_i,
    input  logic                        slot_hit_i,
    input  logic                        rd_vld_i,
    input  ram_data_t                   rd_data_i,
    input  logic                        res_ack_i,
    output logic                        idle_o,
    output logic                        done_o,
    output logic                        rd_req_o,
    output logic [TABLE_ADDR_WIDTH-1:0] addr_o,
    output ht_search_res_t              res_o
);

    localparam int unsigned HOP_W = (MAX_CHAIN > 1) ? $clog2(MAX_CHAIN) : 1;
    localparam logic [HOP_W-1:0] LAST_HOP = HOP_W'(MAX_CHAIN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_SLOT,
        S_WAIT_DATA,
        S_DONE
    } eng_state_t;

    eng_state_t                  state;
    logic [HOP_W-1:0]            hops;
    logic [TABLE_ADDR_WIDTH-1:0] addr_q;
    ht_search_res_t              res_q;
    logic                        key_hit;
    logic                        last_hop;

    assign key_hit  = (rd_data_i.key == res_q.key);
    assign last_hop = (hops == LAST_HOP);

    assign idle_o   = (state == S_IDLE);
    assign done_o   = (state == S_DONE);
    assign rd_req_o = (state == S_WAIT_SLOT) && slot_hit_i;
    assign addr_o   = addr_q;
    assign res_o    = res_q;

    // Control FSM: state and hop count, cleared by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
            hops  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        hops  <= '0;
                        state <= task_i.head_ptr_val ? S_WAIT_SLOT : S_DONE;
                    end
                end
                S_WAIT_SLOT: begin
                    if (slot_hit_i) state <= S_WAIT_DATA;
                end
                S_WAIT_DATA: begin
                    if (rd_vld_i) begin
                        if (key_hit || !rd_data_i.next_ptr_val || last_hop) begin
                            state <= S_DONE;
                        end else begin
                            hops  <= hops + 1'b1;
                            state <= S_WAIT_SLOT;
                        end
                    end
                end
                S_DONE: begin
                    if (res_ack_i) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Task/result data: latched on accept, updated on each owned RAM return.
    always_ff @(posedge clk_i) begin
        if ((state == S_IDLE) && start_i) begin
            res_q.id     <= task_i.id;
            res_q.key    <= task_i.key;
            res_q.value  <= '0;
            res_q.status <= NOT_FOUND;
            addr_q       <= task_i.head_ptr;
        end else if ((state == S_WAIT_DATA) && rd_vld_i) begin
            if (key_hit) begin
                res_q.value  <= rd_data_i.value;
                res_q.status <= FOUND;
            end else if (!rd_data_i.next_ptr_val) begin
                res_q.status <= NOT_FOUND;
            end else if (last_hop) begin
                res_q.status <= CHAIN_LIMIT;
            end else begin
                addr_q <= rd_data_i.next_ptr;
            end
        end
    end

endmodule

// File: rtl/data_table_search_pool.sv
// Pool of hash-chain search engines sharing one RAM read port through a
// round-robin slot counter, with lowest-free dispatch and round-robin result merge.
module data_table_search_pool
    import hash_table::*;
#(
    parameter int unsigned ENGINES_CNT = 4,
    parameter int unsigned RAM_LATENCY = 2,
    parameter int unsigned A_WIDTH     = TABLE_ADDR_WIDTH,
    parameter int unsigned MAX_CHAIN   = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    data_table_search_pool_if.slave    sp,
    output logic [A_WIDTH-1:0]         rd_addr_o,
    output logic                       rd_en_o,
    input  ram_data_t                  rd_data_i
);

    localparam int unsigned IDX_W = (ENGINES_CNT > 1) ? $clog2(ENGINES_CNT) : 1;

    logic [IDX_W-1:0]            slot_q;
    logic [RAM_LATENCY-1:0]      tag_vld;
    logic [IDX_W-1:0]            tag_idx [RAM_LATENCY];

    logic [ENGINES_CNT-1:0]      eng_idle;
    logic [ENGINES_CNT-1:0]      eng_done;
    logic [ENGINES_CNT-1:0]      eng_rd_req;
    logic [TABLE_ADDR_WIDTH-1:0] eng_addr [ENGINES_CNT];
    ht_search_res_t              eng_res  [ENGINES_CNT];

    logic                        run_q;
    logic                        any_idle;
    logic [IDX_W-1:0]            disp_idx;
    logic                        accept;

    logic [IDX_W-1:0]            rr_ptr;
    logic                        lock_q;
    logic [IDX_W-1:0]            lock_idx_q;
    logic                        rr_found;
    logic [IDX_W-1:0]            rr_idx;
    logic [IDX_W-1:0]            grant;
    int                          arb_cand;
    logic                        res_hs;

    // Slot pointer: one engine owns the RAM port each cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_q <= '0;
        end else if (slot_q == IDX_W'(ENGINES_CNT - 1)) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_q + 1'b1;
        end
    end

    // Tag line: remembers which engine owns each in-flight read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_vld <= '0;
            tag_idx <= '{default: '0};
        end else begin
            tag_vld[0] <= rd_en_o;
            tag_idx[0] <= slot_q;
            for (int i = 1; i < int'(RAM_LATENCY); i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_idx[i] <= tag_idx[i-1];
            end
        end
    end

    for (genvar g = 0; g < ENGINES_CNT; g++) begin : g_eng
        data_table_search_engine #(
            .MAX_CHAIN (MAX_CHAIN)
        ) u_eng (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .start_i    (accept && (disp_idx == IDX_W'(g))),
            .task_i     (sp.task_i),
            .slot_hit_i (slot_q == IDX_W'(g)),
            .rd_vld_i   (tag_vld[RAM_LATENCY-1] && (tag_idx[RAM_LATENCY-1] == IDX_W'(g))),
            .rd_data_i  (rd_data_i),
            .res_ack_i  (res_hs && (grant == IDX_W'(g))),
            .idle_o     (eng_idle[g]),
            .done_o     (eng_done[g]),
            .rd_req_o   (eng_rd_req[g]),
            .addr_o     (eng_addr[g]),
            .res_o      (eng_res[g])
        );
    end

    // RAM port mux: at most one engine requests per cycle, so a plain OR-mux suffices.
    always_comb begin
        rd_en_o   = 1'b0;
        rd_addr_o = '0;
        for (int i = 0; i < int'(ENGINES_CNT); i++) begin
            if (eng_rd_req[IDX_W'(i)]) begin
                rd_en_o   = 1'b1;
                rd_addr_o = A_WIDTH'(eng_addr[i]);
            end
        end
    end

    // Dispatch priority encoder: lowest-index idle engine takes the next task.
    always_comb begin
        any_idle = 1'b0;
        disp_idx = '0;
        for (int i = int'(ENGINES_CNT) - 1; i >= 0; i--) begin
            if (eng_idle[IDX_W'(i)]) begin
                any_idle = 1'b1;
                disp_idx = IDX_W'(i);
            end
        end
    end

    assign sp.task_ready_o = run_q && any_idle;
    assign accept          = sp.task_valid_i && sp.task_ready_o;

    // Result arbiter search: first done engine at or after the round-robin pointer.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = rr_ptr;
        arb_cand = 0;
        for (int k = 0; k < int'(ENGINES_CNT); k++) begin
            arb_cand = (int'(rr_ptr) + k) % int'(ENGINES_CNT);
            if (!rr_found && eng_done[IDX_W'(arb_cand)]) begin
                rr_found = 1'b1;
                rr_idx   = IDX_W'(arb_cand);
            end
        end
    end

    assign grant             = lock_q ? lock_idx_q : rr_idx;
    assign sp.result_valid_o = lock_q || rr_found;
    assign res_hs            = sp.result_valid_o && sp.result_ready_i;
    assign sp.result_o       = sp.result_valid_o ? eng_res[grant] : '0;

    // Arbiter state: freeze an offered-but-stalled grant, advance past each handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run_q      <= 1'b0;
            rr_ptr     <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            run_q      <= 1'b1;
            lock_q     <= sp.result_valid_o && !sp.result_ready_i;
            lock_idx_q <= grant;
            if (res_hs) begin
                if (grant == IDX_W'(ENGINES_CNT - 1)) rr_ptr <= '0;
                else                                  rr_ptr <= grant + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_table_search_pool.sv
// Scoreboard bench for the search pool: directed tasks against a small RAM model.
module tb_data_table_search_pool;
    import hash_table::*;

    localparam int unsigned ENG  = 4;
    localparam int unsigned LAT  = 3;
    localparam int unsigned MAXC = 4;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [TABLE_ADDR_WIDTH-1:0] rd_addr;
    logic                        rd_en;
    ram_data_t                   rd_data;

    data_table_search_pool_if sp_if();

    data_table_search_pool #(
        .ENGINES_CNT (ENG),
        .RAM_LATENCY (LAT),
        .A_WIDTH     (TABLE_ADDR_WIDTH),
        .MAX_CHAIN   (MAXC)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .sp        (sp_if),
        .rd_addr_o (rd_addr),
        .rd_en_o   (rd_en),
        .rd_data_i (rd_data)
    );

    always #5 clk = ~clk;

    ram_data_t                   mem  [256];
    ram_data_t                   pipe [LAT];
    logic [TABLE_ADDR_WIDTH-1:0] cap_addr = '0;
    logic [TABLE_ADDR_WIDTH-1:0] rd_log [$];
    ht_search_res_t              exp_q [$];
    logic [ID_WIDTH-1:0]         got_ids [$];
    int                          total = 0;
    int                          bad   = 0;
    ht_search_res_t              mon_got;
    int                          mon_hit;

    assign rd_data = pipe[LAT-1];

    // RAM model: address captured mid-cycle, data appears LAT cycles after the read.
    always @(negedge clk) begin
        cap_addr = rd_addr;
        if (rd_en) rd_log.push_back(rd_addr);
    end

    always @(posedge clk) begin
        pipe[0] <= mem[cap_addr];
        for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
    end

    function automatic void check(string name, logic [63:0] act, logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endfunction

    function automatic ht_search_res_t mk_res(logic [ID_WIDTH-1:0] id, logic [KEY_WIDTH-1:0] key,
                                              logic [VALUE_WIDTH-1:0] value, ht_status_t st);
        ht_search_res_t r;
        r.id     = id;
        r.key    = key;
        r.value  = value;
        r.status = st;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one task (called just after a rising edge); expected result queued on accept.
    task automatic send_task(input logic [ID_WIDTH-1:0] id, input logic [KEY_WIDTH-1:0] key,
                             input logic [TABLE_ADDR_WIDTH-1:0] head, input logic hv,
                             input ht_search_res_t expr);
        int n;
        n = 0;
        sp_if.task_i.id           = id;
        sp_if.task_i.key          = key;
        sp_if.task_i.head_ptr     = head;
        sp_if.task_i.head_ptr_val = hv;
        sp_if.task_valid_i        = 1'b1;
        @(negedge clk);
        while (!sp_if.task_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!sp_if.task_ready_o) check($sformatf("accept_id%0d", id), 64'(sp_if.task_ready_o), 64'd1);
        else exp_q.push_back(expr);
        @(posedge clk);
        #1;
        sp_if.task_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        repeat (2) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"},        64'(rd_en),                 64'd0);
        check({tag, "_rd_addr"},      64'(rd_addr),               64'd0);
        check({tag, "_task_ready"},   64'(sp_if.task_ready_o),    64'd0);
        check({tag, "_result_valid"}, 64'(sp_if.result_valid_o),  64'd0);
        check({tag, "_result"},       64'(sp_if.result_o),        64'd0);
    endtask

    // Monitor: every result handshake is matched by id against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && sp_if.result_valid_o && sp_if.result_ready_i) begin
                mon_got = sp_if.result_o;
                got_ids.push_back(mon_got.id);
                mon_hit = -1;
                foreach (exp_q[i]) if (mon_hit < 0 && exp_q[i].id == mon_got.id) mon_hit = i;
                if (mon_hit < 0) begin
                    total++;
                    bad++;
                    $display("FAIL result_unexpected: got id %0d result 0x%0h, none outstanding",
                             mon_got.id, mon_got);
                end else begin
                    check($sformatf("result_id%0d", mon_got.id), 64'(mon_got), 64'(exp_q[mon_hit]));
                    exp_q.delete(mon_hit);
                end
            end
        end
    end

    initial begin
        int cnt;
        sp_if.task_valid_i   = 1'b0;
        sp_if.task_i         = '0;
        sp_if.result_ready_i = 1'b1;
        foreach (mem[i]) mem[i] = '0;
        foreach (pipe[i]) pipe[i] = '0;
        mem[8'h10] = '{key: 16'h1111, value: 16'h0010, next_ptr: 8'h22, next_ptr_val: 1'b1};
        mem[8'h22] = '{key: 16'h2222, value: 16'h0022, next_ptr: 8'h35, next_ptr_val: 1'b1};
        mem[8'h35] = '{key: 16'hABCD, value: 16'h5A5A, next_ptr: 8'h00, next_ptr_val: 1'b0};
        mem[8'h01] = '{key: 16'h0101, value: 16'h0001, next_ptr: 8'h02, next_ptr_val: 1'b1};
        mem[8'h02] = '{key: 16'h0202, value: 16'h0002, next_ptr: 8'h01, next_ptr_val: 1'b1};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        step();
        rst = 1'b0;
        step();
        @(negedge clk);
        check("ready_after_reset", 64'(sp_if.task_ready_o), 64'd1);
        step();

        // empty bucket: result one cycle after accept, no RAM read
        rd_log.delete();
        send_task(4'd3, 16'h0333, 8'h00, 1'b0, mk_res(4'd3, 16'h0333, 16'h0000, NOT_FOUND));
        @(negedge clk);
        check("empty_valid_t1", 64'(sp_if.result_valid_o), 64'd1);
        wait_drain("empty", 50);
        check("empty_no_read", 64'(rd_log.size()), 64'd0);

        // hit at third hop
        rd_log.delete();
        send_task(4'd5, 16'hABCD, 8'h10, 1'b1, mk_res(4'd5, 16'hABCD, 16'h5A5A, FOUND));
        wait_drain("hit3", 200);
        check("hit3_reads", 64'(rd_log.size()), 64'd3);
        check("hit3_rd0", 64'(rd_log[0]), 64'h10);
        check("hit3_rd1", 64'(rd_log[1]), 64'h22);
        check("hit3_rd2", 64'(rd_log[2]), 64'h35);

        // cyclic chain stopped by hop guard
        rd_log.delete();
        send_task(4'd6, 16'h7777, 8'h01, 1'b1, mk_res(4'd6, 16'h7777, 16'h0000, CHAIN_LIMIT));
        wait_drain("guard", 200);
        check("guard_reads", 64'(rd_log.size()), 64'd4);
        check("guard_rd0", 64'(rd_log[0]), 64'h01);
        check("guard_rd1", 64'(rd_log[1]), 64'h02);
        check("guard_rd2", 64'(rd_log[2]), 64'h01);
        check("guard_rd3", 64'(rd_log[3]), 64'h02);

        // miss at end of chain
        rd_log.delete();
        send_task(4'd7, 16'h9999, 8'h22, 1'b1, mk_res(4'd7, 16'h9999, 16'h0000, NOT_FOUND));
        wait_drain("miss", 200);
        check("miss_reads", 64'(rd_log.size()), 64'd2);

        // saturation: six tasks into four engines
        rd_log.delete();
        got_ids.delete();
        sp_if.result_ready_i = 1'b0;
        for (int i = 8; i < 12; i++)
            send_task(4'(i), 16'hABCD, 8'h10, 1'b1, mk_res(4'(i), 16'hABCD, 16'h5A5A, FOUND));
        @(negedge clk);
        check("sat_ready_low", 64'(sp_if.task_ready_o), 64'd0);
        step();
        sp_if.result_ready_i = 1'b1;
        for (int i = 12; i < 14; i++)
            send_task(4'(i), 16'h7777, 8'h22, 1'b1, mk_res(4'(i), 16'h7777, 16'h0000, NOT_FOUND));
        wait_drain("sat", 400);
        check("sat_results", 64'(got_ids.size()), 64'd6);
        check("sat_reads", 64'(rd_log.size()), 64'd16);
        for (int id = 8; id < 14; id++) begin
            cnt = 0;
            foreach (got_ids[j]) if (got_ids[j] == 4'(id)) cnt++;
            check($sformatf("sat_once_id%0d", id), 64'(cnt), 64'd1);
        end

        // backpressure: three done engines held, then drained round-robin
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        got_ids.delete();
        sp_if.result_ready_i = 1'b0;
        send_task(4'd1, 16'h0A01, 8'h00, 1'b0, mk_res(4'd1, 16'h0A01, 16'h0000, NOT_FOUND));
        send_task(4'd2, 16'h0A02, 8'h00, 1'b0, mk_res(4'd2, 16'h0A02, 16'h0000, NOT_FOUND));
        send_task(4'd4, 16'h0A04, 8'h00, 1'b0, mk_res(4'd4, 16'h0A04, 16'h0000, NOT_FOUND));
        repeat (20) begin
            @(negedge clk);
            check("bp_valid", 64'(sp_if.result_valid_o), 64'd1);
            check("bp_hold", 64'(sp_if.result_o), 64'(mk_res(4'd1, 16'h0A01, 16'h0000, NOT_FOUND)));
        end
        step();
        sp_if.result_ready_i = 1'b1;
        wait_drain("bp", 50);
        check("bp_count", 64'(got_ids.size()), 64'd3);
        check("bp_order0", 64'(got_ids[0]), 64'd1);
        check("bp_order1", 64'(got_ids[1]), 64'd2);
        check("bp_order2", 64'(got_ids[2]), 64'd4);

        // reset one cycle after a read: late RAM data must not produce a result
        send_task(4'd9, 16'hABCD, 8'h35, 1'b1, mk_res(4'd9, 16'hABCD, 16'h5A5A, FOUND));
        cnt = 0;
        @(negedge clk);
        while (!rd_en && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("rst_read_seen", 64'(rd_en), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        exp_q.delete();
        step();
        rst = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (sp_if.result_valid_o) cnt++;
        end
        check("midrst_no_late_result", 64'(cnt), 64'd0);
        check("midrst_ready_back", 64'(sp_if.task_ready_o), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
